// File: rtl/sub_layer_seq.sv
// rtl/sub_layer_seq.sv - sequential PRESENT sbox layer, one nibble (or nibble pair) per cycle
// SUB_LAYER_FAST_EN: two sbox lanes per cycle, halving latency.

module sbox (
  input  logic [3:0] x,
  output logic [3:0] r
);
  always_comb begin
    case (x)
      4'h0: r = 4'hC;
      4'h1: r = 4'h5;
      4'h2: r = 4'h6;
      4'h3: r = 4'hB;
      4'h4: r = 4'h9;
      4'h5: r = 4'h0;
      4'h6: r = 4'hA;
      4'h7: r = 4'hD;
      4'h8: r = 4'h3;
      4'h9: r = 4'hE;
      4'hA: r = 4'hF;
      4'hB: r = 4'h8;
      4'hC: r = 4'h4;
      4'hD: r = 4'h7;
      4'hE: r = 4'h1;
      default: r = 4'h2;
    endcase
  end
endmodule

module sub_layer_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] x,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] r
);

`ifdef SUB_LAYER_FAST_EN
  localparam int LANE = 8;
`else
  localparam int LANE = 4;
`endif
  localparam int STEPS = WIDTH / LANE;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_upd;
  logic [LANE-1:0]  lane_in;
  logic [LANE-1:0]  lane_out;
  int               idx;

  always_comb begin
    idx     = int'(cnt) * LANE;
    lane_in = w[idx +: LANE];
    w_upd   = w;
    w_upd[idx +: LANE] = lane_out;
  end

  // The shared sbox lanes see whichever slice cnt currently points at.
  for (genvar g = 0; g < LANE / 4; g++) begin : g_lane
    sbox u_sbox (
      .x (lane_in[4*g +: 4]),
      .r (lane_out[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      busy  <= 1'b0;
      r     <= '0;
      cnt   <= '0;
      w     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            w     <= x;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          w <= w_upd;
          if (cnt == LAST) begin
            r     <= w_upd;
            ack   <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // Result is held until the requester withdraws; no back-to-back capture.
          if (!req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_layer_seq.sv
// tb/tb_sub_layer_seq.sv - directed self-checking bench for sub_layer_seq

module tb_sub_layer_seq;

`ifdef SUB_LAYER_FAST_EN
  localparam int LAT   = 9;
  localparam int BUSYN = 8;
`else
  localparam int LAT   = 17;
  localparam int BUSYN = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [63:0] x;
  logic        ack;
  logic        busy;
  logic [63:0] r;

  int total = 0;
  int bad   = 0;
  int lat;
  int bcnt;

  sub_layer_seq #(.WIDTH(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .x    (x),
    .ack  (ack),
    .busy (busy),
    .r    (r)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation; lat counts edges from capture (inclusive) until ack is seen.
  task automatic do_op(input logic [63:0] xin, input logic hold_req, input logic scramble,
                       output int l, output int b);
    x   = xin;
    req = 1'b1;
    l   = 0;
    b   = 0;
    do begin
      step();
      l++;
      if (l == 1 && !hold_req) req = 1'b0;
      if (l == 1 && scramble) x = 64'hFFFF_FFFF_FFFF_FFFF;
      if (busy) b++;
    end while (!ack && l < 60);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b1;
    x   = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ack", {63'd0, ack}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_r", r, 64'd0);
    end

    // Capture on first edge after reset release; req then held through DONE.
    rst = 1'b0;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, lat, bcnt);
    check("t1_lat", 64'(lat), 64'(LAT));
    check("t1_busy_cycles", 64'(bcnt), 64'(BUSYN));
    check("t1_r", r, 64'h2222_2222_2222_2222);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_hold_ack", {63'd0, ack}, 64'd1);
      check("t1_hold_busy", {63'd0, busy}, 64'd0);
    end
    req = 1'b0;
    step();
    check("t1_ack_fall", {63'd0, ack}, 64'd0);
    check("t1_r_kept", r, 64'h2222_2222_2222_2222);

    do_op(64'h0, 1'b1, 1'b0, lat, bcnt);
    check("t2_lat", 64'(lat), 64'(LAT));
    check("t2_busy_cycles", 64'(bcnt), 64'(BUSYN));
    check("t2_r", r, 64'hCCCC_CCCC_CCCC_CCCC);
    req = 1'b0;
    step();
    check("t2_ack_fall", {63'd0, ack}, 64'd0);

    do_op(64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, lat, bcnt);
    check("t3_lat", 64'(lat), 64'(LAT));
    check("t3_r", r, 64'hC56B_90AD_3EF8_4712);
    req = 1'b0;
    step();
    check("t3_ack_fall", {63'd0, ack}, 64'd0);

    // Single-cycle request still completes, yielding a one-cycle ack pulse.
    do_op(64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, lat, bcnt);
    check("t4_lat", 64'(lat), 64'(LAT));
    check("t4_r", r, 64'h2174_8FE3_DA09_B65C);
    step();
    check("t4_pulse_end", {63'd0, ack}, 64'd0);
    check("t4_r_kept", r, 64'h2174_8FE3_DA09_B65C);

    // Abort mid-operation with reset at E0+7.
    x   = 64'h0123_4567_89AB_CDEF;
    req = 1'b1;
    step();
    check("t5_busy", {63'd0, busy}, 64'd1);
    req = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    check("t5_abort_ack", {63'd0, ack}, 64'd0);
    check("t5_abort_busy", {63'd0, busy}, 64'd0);
    check("t5_abort_r", r, 64'd0);
    rst = 1'b0;
    step();
    check("t5_idle_r", r, 64'd0);
    check("t5_idle_ack", {63'd0, ack}, 64'd0);
    do_op(64'h1111_1111_1111_1111, 1'b1, 1'b0, lat, bcnt);
    check("t5_lat", 64'(lat), 64'(LAT));
    check("t5_r", r, 64'h5555_5555_5555_5555);
    req = 1'b0;
    step();
    check("t5_ack_fall", {63'd0, ack}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
